// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Provides the loader state enum, header sizing and small state helpers.
package imem_loader_pkg;

    // Length header: LEN_LO then LEN_HI, little-endian word count.
    localparam int HDR_BYTES = 2;
    localparam int LEN_W     = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) ||
               (s == DATA)   || (s == CSUM);
    endfunction

    // States in which a start pulse begins a new load.
    function automatic logic is_start_state(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a byte stream into 32-bit little-endian words.
// Ports: clk, reset (sync, active-high), clr (restart framing),
//        byte_in/byte_valid (accepted byte), lane (next target byte),
//        word_valid (one-cycle pulse) and word (registered result).
module byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [1:0]  lane,
    output logic        word_valid,
    output logic [31:0] word
);

    // Lower three bytes of the word under construction.
    logic [23:0] pack;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= 2'd0;
            pack       <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                lane <= 2'd0;
                pack <= 24'd0;
            end else if (byte_valid) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0: pack[7:0]   <= byte_in;
                    2'd1: pack[15:8]  <= byte_in;
                    2'd2: pack[23:16] <= byte_in;
                    2'd3: begin
                        // Word output is separate from pack so the
                        // next word can start while this one is written.
                        word       <= {byte_in, pack};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory
// and holds the core in reset until the image is fully loaded.
// Ports: clk, reset (sync, active-high), start (begin load),
//        rx_data/rx_valid/rx_ready (byte stream), im_wr_en/im_wr_addr/
//        im_wr_data (memory write port), cpu_reset, boot_addr, done, error.
// Optional feature: define IMEM_LOADER_CSUM_EN for a trailing
// 8-bit checksum byte (image sum + checksum == 0 mod 256).
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [31:0]       im_wr_data,
    output logic              cpu_reset,
    output logic [31:0]       boot_addr,
    output logic              done,
    output logic              error
);

    import imem_loader_pkg::*;

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif

    state_t state;
    state_t nxt;

    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] wcnt;
    logic [LEN_W-1:0] hdr_len;

    logic       acc;
    logic       data_acc;
    logic       start_ok;
    logic       too_big;
    logic       last_word;
    logic       last_byte;
    logic       wr_last;
    logic       csum_ok;

    logic [1:0]  lane;
    logic        word_valid;
    logic [31:0] word;

    assign acc      = rx_valid && rx_ready;
    assign data_acc = acc && (state == DATA);
    assign start_ok = start && is_start_state(state);

    assign hdr_len = {rx_data, len_lo};
    assign too_big = {1'b0, hdr_len} > DEPTH_L;

    // wcnt only advances during the write pulse, so it still
    // indexes the current word both on its last byte and its write.
    assign last_word = (wcnt + LEN_W'(1)) == len;
    assign last_byte = data_acc && (lane == 2'd3) && last_word;
    assign wr_last   = word_valid && (state == DATA) && last_word;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] sum;
    logic [7:0] total;

    assign total   = sum + rx_data;
    assign csum_ok = (total == 8'h00);

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            sum <= 8'h00;
        end else if (acc && (state != CSUM)) begin
            sum <= total;
        end
    end
`else
    assign csum_ok = 1'b0;
`endif

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (start_ok),
        .byte_in    (rx_data),
        .byte_valid (data_acc),
        .lane       (lane),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start) nxt = LEN_LO;
            end
            LEN_LO: begin
                if (acc) nxt = LEN_HI;
            end
            LEN_HI: begin
                if (acc) begin
                    if (too_big) begin
                        nxt = ERR;
                    end else if (hdr_len == '0) begin
                        nxt = FIN;
                    end else begin
                        nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (wr_last) nxt = FIN;
            end
            CSUM: begin
                if (acc) nxt = csum_ok ? DONE : ERR;
            end
            DONE, ERR: begin
                if (start) nxt = LEN_LO;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state)
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Ready closes for the one cycle between the final data byte
    // and its write pulse, so no stray byte enters the next field.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ready <= 1'b0;
        end else begin
            rx_ready <= is_rx_state(nxt) && !last_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo <= 8'd0;
            len    <= '0;
            wcnt   <= '0;
        end else if (start_ok) begin
            len_lo <= 8'd0;
            len    <= '0;
            wcnt   <= '0;
        end else begin
            if (acc && (state == LEN_LO)) len_lo <= rx_data;
            if (acc && (state == LEN_HI)) len <= hdr_len;
            if (word_valid) wcnt <= wcnt + LEN_W'(1);
        end
    end

    assign im_wr_en   = word_valid;
    assign im_wr_data = word;
    assign im_wr_addr = wcnt[ADDR_W-1:0];
    assign boot_addr  = BOOT_ADDR;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random image loads
// compared against a frame-level model of expected writes and outcome.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int          DEPTH  = 256;
    localparam int          ADDR_W = 8;
    localparam logic [31:0] BOOT   = 32'h8000_0100;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_wr_en;
    logic [ADDR_W-1:0] im_wr_addr;
    logic [31:0]       im_wr_data;
    logic              cpu_reset;
    logic [31:0]       boot_addr;
    logic              done;
    logic              error;

    imem_loader #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BOOT_ADDR (BOOT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .cpu_reset  (cpu_reset),
        .boot_addr  (boot_addr),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int cyc         = 0;
    int last_wr_cyc = -1;
    int done_cyc    = -1;
    logic done_prev = 1'b0;
    int wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    logic [31:0] img[$];
    logic [7:0]  sum;
    bit          in_data;
    int          ready_drops;
    int          timeouts;

    always @(negedge clk) begin
        cyc++;
        if (im_wr_en) begin
            wr_addr_q.push_back(int'(im_wr_addr));
            wr_data_q.push_back(im_wr_data);
            last_wr_cyc = cyc;
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: continuous, 1: valid toggles each cycle, 2: random gaps
    task automatic send(input logic [7:0] b, input int mode);
        bit ok = 1'b0;
        int budget = 64;
        while (!ok && budget > 0) begin
            @(negedge clk);
            rx_data = b;
            case (mode)
                1:       rx_valid = ~rx_valid;
                2:       rx_valid = ($urandom_range(0, 2) != 0);
                default: rx_valid = 1'b1;
            endcase
            if (in_data && !rx_ready) ready_drops++;
            ok = rx_valid && rx_ready;
            budget--;
        end
        if (!ok) timeouts++;
        sum = sum + b;
    endtask

    task automatic release_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Frame model: N <= DEPTH writes img[i] at word i and ends in DONE
    // unless the checksum is off; N > DEPTH aborts after the header.
    task automatic do_load(input string tag, input int n, input int mode,
                           input int csum_delta);
        bit exp_err;
        int exp_wr;
        int w;
        logic [31:0] word;
        logic [15:0] nh;
        logic [7:0]  cb;
        wr_addr_q.delete();
        wr_data_q.delete();
        ready_drops = 0;
        timeouts    = 0;
        sum         = 8'h00;
        done_cyc    = -1;
        last_wr_cyc = -1;
        nh = 16'(n);
        exp_err = (n > DEPTH);
        exp_wr  = exp_err ? 0 : n;
        pulse_start();
        send(nh[7:0], mode);
        send(nh[15:8], mode);
        if (!exp_err) begin
            in_data = 1'b1;
            for (int i = 0; i < n; i++) begin
                word = img[i];
                for (int k = 0; k < 4; k++) send(word[8*k +: 8], mode);
            end
            in_data = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            cb = 8'(256 - int'(sum) + csum_delta);
            send(cb, mode);
            exp_err = (csum_delta != 0);
`else
            cb = 8'(csum_delta);
`endif
        end
        release_rx();
        w = 0;
        while (!(done || error) && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        check({tag, " timeouts"}, 32'(timeouts), 32'd0);
        check({tag, " done"}, 32'(done), 32'(!exp_err));
        check({tag, " error"}, 32'(error), 32'(exp_err));
        check({tag, " cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
        check({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, " ready drops"}, 32'(ready_drops), 32'd0);
        check({tag, " nwrites"}, 32'(wr_addr_q.size()), 32'(exp_wr));
        for (int i = 0; i < wr_addr_q.size() && i < exp_wr; i++) begin
            check($sformatf("%s addr%0d", tag, i),
                  32'(wr_addr_q[i]), 32'(i));
            check($sformatf("%s data%0d", tag, i),
                  wr_data_q[i], img[i]);
        end
`ifndef IMEM_LOADER_CSUM_EN
        if (n > 0 && !exp_err)
            check({tag, " done latency"}, 32'(done_cyc - last_wr_cyc), 32'd1);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        in_data  = 1'b0;
        sum      = 8'h00;
        repeat (3) @(negedge clk);
        check("rst rx_ready", 32'(rx_ready), 32'd0);
        check("rst wr_en", 32'(im_wr_en), 32'd0);
        check("rst wr_addr", 32'(im_wr_addr), 32'd0);
        check("rst wr_data", im_wr_data, 32'd0);
        check("rst cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst boot_addr", boot_addr, BOOT);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle cpu_reset", 32'(cpu_reset), 32'd1);

        img = '{32'h0000_0013, 32'h0010_0093};
        do_load("n2", 2, 0, 0);

        do_load("n257", 257, 0, 0);

        fill_random(1);
        do_load("n1 toggle", 1, 1, 0);

`ifdef IMEM_LOADER_CSUM_EN
        img = '{32'h0403_0201};
        do_load("csum ok", 1, 0, 0);
        do_load("csum bad", 1, 0, -1);
`endif

        // Abort after three data bytes of a two-word image.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send(8'd2, 0);
        send(8'd0, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort rx_ready", 32'(rx_ready), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("abort nwrites", 32'(wr_addr_q.size()), 32'd0);
        fill_random(2);
        do_load("after abort", 2, 0, 0);

        img.delete();
        do_load("n0", 0, 0, 0);
        pulse_start();
        check("restart cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart done", 32'(done), 32'd0);
        check("restart rx_ready", 32'(rx_ready), 32'd1);
        fill_random(3);
        do_load("after restart", 3, 2, 0);

        for (int r = 0; r < 5; r++) begin
            int n = $urandom_range(1, 20);
            fill_random(n);
            do_load($sformatf("rand%0d", r), n, $urandom_range(0, 2), 0);
        end

        fill_random(DEPTH);
        do_load("full depth", DEPTH, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RISC-V core. It accepts a byte stream (e.g. from a UART receiver) carrying a length header, instruction words and an optional checksum. It assembles the bytes into 32-bit little-endian words and writes them sequentially into instruction memory. It holds the core in reset until the image is fully and correctly loaded, then releases it with the boot address driven onto the core's `IAddress`.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory size in 32-bit words.
- `ADDR_W`, `$clog2(DEPTH)`: word-index width of the write port.
- `BOOT_ADDR`, 32'h0000_0000: byte address presented on `boot_addr`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load; honoured in IDLE, DONE and ERR.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `im_wr_en` out 1: instruction memory write strobe.
- `im_wr_addr` out ADDR_W: word index.
- `im_wr_data` out 32: assembled word.
- `cpu_reset` out 1: hold-reset to the core.
- `boot_addr` out 32: constant `BOOT_ADDR`, wired to the core `IAddress`.
- `done` out 1: image loaded, core running.
- `error` out 1: load aborted.

## Operation
- Frame format: `LEN_LO`, `LEN_HI` (N = 16-bit word count, little-endian), then 4·N data bytes, each word sent LSB first, then `CSUM` (only under `IMEM_LOADER_CSUM_EN`).
- A byte is accepted on a cycle with `rx_valid && rx_ready`.
- States and transitions:
  - IDLE: `start` → LEN_LO.
  - LEN_LO: byte accepted → LEN_HI.
  - LEN_HI: byte accepted; then
    - N > DEPTH → ERR;
    - N == 0 → CSUM (with the macro) or DONE (without it);
    - otherwise → DATA.
  - DATA: after the 4th byte of word N−1 → CSUM (with the macro) or DONE (without it).
  - CSUM: byte accepted; match → DONE, mismatch → ERR.
  - DONE, ERR: `start` → LEN_LO, clearing the counters and the checksum.
- `rx_ready` = 1 only in LEN_LO, LEN_HI, DATA and CSUM.
- Byte lane counter (2 bits) selects the target byte of the word; it wraps 3→0 on each completed word.
- Word counter (16 bits) starts at 0 and increments after each write; `im_wr_addr` = word counter[ADDR_W-1:0].
- `cpu_reset` = 1 in every state except DONE.
- `done` = 1 only in DONE; `error` = 1 only in ERR.
- `start` received in LEN_LO..CSUM is ignored.
- `reset` in any state aborts the load: the partial image remains in memory, and the state returns to IDLE.

## Timing
- Reset values:
  - state IDLE;
  - `rx_ready` 0, `im_wr_en` 0, `im_wr_addr` 0, `im_wr_data` 0;
  - `cpu_reset` 1, `done` 0, `error` 0;
  - `boot_addr` = BOOT_ADDR.
- `im_wr_en` pulses for exactly one cycle, the cycle after the 4th byte of a word is accepted. `im_wr_addr` and `im_wr_data` are registered and stable during that cycle.
- `rx_ready` is registered from the state. A byte is accepted at most once per cycle, so throughput is 1 byte per cycle.
- `rx_valid` low stalls every counter; there is no timeout.
- DONE is entered on the cycle after the final data byte's write pulse, or after the CSUM byte. `cpu_reset` falls on that same cycle.
- Restarting from DONE re-asserts `cpu_reset` on the cycle after `start`.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - running 8-bit sum (mod 256) of the LEN_LO, LEN_HI and all data bytes;
  - a trailing CSUM byte must equal the two's complement of that sum, so the total is 0 mod 256;
  - mismatch → ERR.
- Undefined: no CSUM state, no checksum hardware; the frame ends after the data bytes.

## Structure
- `imem_loader_pkg`: state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR) and header byte count constant (2).
- Sub-module `byte_assembler`: 2-bit lane counter plus 32-bit little-endian packing register, producing `word_valid` and `word`.

## Test plan
- DEPTH=256, N=2, bytes 13 00 00 00 93 00 10 00 → writes addr0=32'h0000_0013 and addr1=32'h0010_0093; `done`=1 and `cpu_reset`=0 one cycle after the second write.
- N=257 (header 01 01) → ERR, `error`=1, no `im_wr_en`, `cpu_reset` stays 1.
- `rx_valid` toggling every other cycle during N=1 → single write of the correct word; `rx_ready` never drops in DATA.
- CSUM_EN, N=1, data 01 02 03 04, CSUM 0xF5 → DONE; CSUM 0xF4 → ERR.
- `reset` asserted after 3 data bytes → IDLE, `cpu_reset`=1, no write pulse; a subsequent full load succeeds.
- N=0 → DONE with no writes; then a `start` in DONE → LEN_LO with `cpu_reset`=1.
